// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART types, parity constants and the majority-vote helper
package uart_rx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// rx_data_sampler: three mid-bit samples and a 2-of-3 vote, valid the cycle after the last sample
module rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_s_i,
  input  logic [PRESC_W-1:0] edge_cnt_i,
  input  logic [PRESC_W-1:0] prescale_i,
  input  logic               enable_i,
  output logic               sampled_bit_o,
  output logic               sample_valid_o
);
  logic [PRESC_W-1:0] mid;
  logic [2:0]         samp_q, samp_d;
  logic               valid_q, valid_d;
  // capture the samples around mid-bit and flag when the third one is in
  always_comb begin
    mid       = prescale_i >> 1;
    samp_d[0] = (enable_i && edge_cnt_i == mid - PRESC_W'(1)) ? rx_s_i : samp_q[0];
    samp_d[1] = (enable_i && edge_cnt_i == mid) ? rx_s_i : samp_q[1];
    samp_d[2] = (enable_i && edge_cnt_i == mid + PRESC_W'(1)) ? rx_s_i : samp_q[2];
    valid_d   = enable_i && edge_cnt_i == mid + PRESC_W'(1);
  end
  // sample flops and vote-valid flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      samp_q  <= samp_d;
      valid_q <= valid_d;
    end
  end
  assign sampled_bit_o  = maj3(samp_q);
  assign sample_valid_o = valid_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and stop-bit check
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);
  localparam int BCW = $clog2(DATA_WIDTH);
  rx_state_e             state_q, state_d;
  logic                  sync_q, rx_s_q;
  logic                  armed_q, armed_d;
  logic [PRESC_W-1:0]    presc_q, presc_d, edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, par_fail_q, par_fail_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic                  bit_v, bit_s, wrap;
  rx_data_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .rx_s_i        (rx_s_q),
    .edge_cnt_i    (edge_cnt_q),
    .prescale_i    (presc_q),
    .enable_i      (state_q != IDLE),
    .sampled_bit_o (bit_s),
    .sample_valid_o(bit_v)
  );
  // frame FSM, counters, shift register and frame evaluation
  always_comb begin
    wrap       = edge_cnt_q == presc_q - PRESC_W'(1);
    state_d    = state_q;
    armed_d    = state_q == IDLE && (armed_q || rx_s_q);
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_fail_d = par_fail_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    case (state_q)
      IDLE: if (armed_q && !rx_s_q) begin
        state_d    = START;
        presc_d    = prescale;
        par_en_d   = PAR_EN;
        par_typ_d  = PAR_TYP;
        par_fail_d = 1'b0;
        bit_cnt_d  = '0;
      end
      START: state_d = (bit_v && bit_s) ? IDLE : wrap ? DATA : START;
      DATA: begin
        if (bit_v) shift_d[bit_cnt_q] = bit_s;
        if (wrap) begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_v) par_fail_d = bit_s != (^shift_q ^ par_typ_q);
        if (wrap) state_d = STOP;
      end
      STOP: if (bit_v) begin
        dv_d     = bit_s && !par_fail_q;
        pe_d     = par_fail_q;
        se_d     = !bit_s;
        p_data_d = (bit_s && !par_fail_q) ? shift_q : p_data_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    edge_cnt_d = (state_q == IDLE || state_d == IDLE || wrap) ? '0 : edge_cnt_q + PRESC_W'(1);
  end
  // state, synchronizer and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      presc_q    <= '0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail_q <= 1'b0;
      shift_q    <= '0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      sync_q     <= RX_IN;
      rx_s_q     <= sync_q;
      state_q    <= state_d;
      armed_q    <= armed_d;
      presc_q    <= presc_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_fail_q <= par_fail_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end
  assign P_DATA     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;
endmodule
